cmp_bit_serializer: RTL and testbench
=====================================

Name: cmp_bit_serializer

Overview:
- Output-side counterpart of the FFE/comparator datapath.
- Accepts one numChannels-wide word of sliced bits per clock from the comparator (bit_out bus) and buffers it in a small word FIFO.
- Emits the bits one per handshake as a serial stream, channel 0 first, for the PRBS checker, recorder, or off-chip debug port.
- Provides backpressure upstream and fill/overflow status.

Parameters:
numChannels, 16, parallel word width (matches cmp_gpack::width)
depth, 4, FIFO depth in words; power of 2, >= 2
cntBitwidth, 16, width of dropped-word counter

Ports:
clk  input  1  system clock; all state updates on posedge
rstb  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of FIFO contents and bit index
bits_in  input  numChannels (unpacked [numChannels-1:0])  comparator decisions for one word
in_valid  input  1  bits_in valid this cycle
in_ready  output  1  FIFO can accept a word this cycle
bit_out  output  1  current serial bit
out_valid  output  1  bit_out valid
out_ready  input  1  downstream consumes bit_out this cycle
fill  output  $clog2(depth)+1  words currently stored, including a partially sent head word
dropped  output  cntBitwidth  count of words presented while in_ready was low (saturating)

Behaviour:
- Reset (rstb low, asynchronous): wr_ptr=0, rd_ptr=0, bit_idx=0, fill=0, dropped=0, out_valid=0, in_ready=1, bit_out=0. FIFO storage is not reset. Any word in flight is lost. Behaviour resumes on the first posedge after rstb rises.
- Push:
  - push = in_valid & in_ready.
  - On push, mem[wr_ptr] <= bits_in, and wr_ptr increments mod depth.
- Flow-control signals:
  - in_ready = (fill < depth), combinational from registered fill only.
  - No same-cycle pass-through when full: a pop in the same cycle does not raise in_ready.
- Output:
  - out_valid = (fill != 0).
  - bit_out = mem[rd_ptr][bit_idx] when out_valid, else 0.
  - bit_out and out_valid must be stable while out_valid=1 and out_ready=0.
- Serial handshake:
  - fire = out_valid & out_ready.
  - On fire, bit_idx increments.
  - When bit_idx==numChannels-1 and fire, bit_idx wraps to 0, rd_ptr increments mod depth, and the word pops.
- Bit order:
  - Serial position n = word*numChannels + channel.
  - Channel 0 goes first, channel numChannels-1 goes last.
- Fill update:
  - fill += push, fill -= pop.
  - Simultaneous push and pop leaves fill unchanged.
  - Pointers wrap independently.
- Latency:
  - A word pushed at edge k gives out_valid=1 after edge k (visible in cycle k+1) when the FIFO was empty.
  - Minimum drain time is numChannels cycles per word with out_ready held high.
- Throughput: sustained input is limited to 1 word per numChannels cycles. Faster input fills the FIFO, then deasserts in_ready.
- Overflow:
  - If in_valid=1 and in_ready=0, the word is discarded and dropped increments.
  - dropped saturates at all-ones.
  - Stored data is never overwritten.
- Flush:
  - Sets rd_ptr, wr_ptr, bit_idx and fill to 0 on the next edge. dropped is unchanged.
  - flush has priority over push and pop in the same cycle; that word is not stored.
- Partial word: bit_idx is held across stalls. A word is never popped until all numChannels bits have fired.

Test Plan:
- Single word: reset, push bits_in=16'hA5C3 (channel0=bit0), out_ready=1 -> out_valid rises the next cycle; serial sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; fill returns to 0 after 16 fires.
- Back-to-back fill: push 5 words on consecutive cycles with out_ready=0 -> first 4 accepted, in_ready=0 from the 5th cycle, dropped=1, fill=4, and the first word's bit 0 is held on bit_out.
- Stall mid-word: stream word 16'hFFFF, drop out_ready after 7 fires for 10 cycles -> bit_idx holds at 7, bit_out stays 1, and the remaining 9 bits emit after resume.
- Concurrent push/pop at full: fill=4, assert push (in_ready low, so word dropped) on the same cycle as the last-bit pop -> fill=3, dropped increments, next cycle in_ready=1.
- Flush and reset mid-operation: flush during word 2 bit 5 -> fill=0, out_valid=0 next cycle, dropped retained. Then assert rstb low asynchronously mid-cycle -> all outputs reach reset values immediately, without waiting for a clock edge.
- Long random: 1000 random words pushed at 1/16 rate with random out_ready duty -> serial stream equals the concatenated words in channel order; dropped=0.

Source files
------------

// File: rtl/cmp_bit_serializer.sv
// Word FIFO that turns comparator decision words into a serial bit stream.
// Channel 0 of each word is sent first; overflowed words are counted.
module cmp_bit_serializer #(
  parameter int numChannels = 16,
  parameter int depth       = 4,
  parameter int cntBitwidth = 16
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       flush,
  input  logic                       bits_in [numChannels-1:0],
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       bit_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(depth):0]     fill,
  output logic [cntBitwidth-1:0]     dropped
);

  localparam int AW = $clog2(depth);
  localparam int FW = AW + 1;
  localparam int IW = (numChannels > 1) ? $clog2(numChannels) : 1;

  logic [numChannels-1:0] mem [depth];
  logic [numChannels-1:0] word_in;
  logic [numChannels-1:0] head;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [IW-1:0]          bit_idx;
  logic                   push;
  logic                   fire;
  logic                   last;
  logic                   pop;
  logic                   drop;

  always_comb begin
    word_in = '0;
    for (int i = 0; i < numChannels; i++)
      word_in[i] = bits_in[i];
  end

  assign in_ready  = (fill < FW'(depth));
  assign out_valid = (fill != '0);
  assign head      = mem[rd_ptr];
  assign bit_out   = out_valid ? head[bit_idx] : 1'b0;

  assign push = in_valid & in_ready & ~flush;
  assign drop = in_valid & ~in_ready & ~flush;
  assign fire = out_valid & out_ready & ~flush;
  assign last = (bit_idx == IW'(numChannels - 1));
  assign pop  = fire & last;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      bit_idx <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      bit_idx <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        bit_idx <= '0;
      end else if (fire) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fill <= '0;
    end else begin
      unique case (1'b1)
        flush:       fill <= '0;
        push & ~pop: fill <= fill + 1'b1;
        pop & ~push: fill <= fill - 1'b1;
        default:     fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      dropped <= '0;
    else if (drop && (dropped != '1))
      dropped <= dropped + 1'b1;
  end

endmodule

// File: tb/tb_cmp_bit_serializer.sv
// Directed and random bench for cmp_bit_serializer.
// Expected serial bits are queued on push and checked on each fire.
module tb_cmp_bit_serializer;

  localparam int NC = 16;
  localparam int DP = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstb;
  logic          flush;
  logic          bits_in [NC-1:0];
  logic          in_valid;
  logic          in_ready;
  logic          bit_out;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fill;
  logic [CW-1:0] dropped;

  int checks = 0;
  int errors = 0;
  bit q [$];

  cmp_bit_serializer #(
    .numChannels(NC),
    .depth(DP),
    .cntBitwidth(CW)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .flush(flush),
    .bits_in(bits_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bit_out(bit_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fill(fill),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] w);
    in_valid = 1'b1;
    for (int i = 0; i < NC; i++)
      bits_in[i] = w[i];
  endtask

  task automatic sb_push(input logic [NC-1:0] w);
    for (int i = 0; i < NC; i++)
      q.push_back(w[i]);
  endtask

  function automatic int model_fill();
    return (q.size() + NC - 1) / NC;
  endfunction

  // Fire happens at the next posedge; flush overrides it.
  always @(negedge clk) begin
    if (rstb && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_bit", 32'(bit_out), 32'hdead);
      end else begin
        chk("serial_bit", 32'(bit_out), 32'(q.pop_front()));
      end
    end
  end

  logic [NC-1:0] bb [5];
  logic [NC-1:0] w;
  int gap;
  int sent;
  int cyc;

  initial begin
    rstb = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++)
      bits_in[i] = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bit_out", 32'(bit_out), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    rstb = 1'b1;
    tick();

    // Single word, checked against the spec's literal sequence too
    out_ready = 1'b1;
    drive(16'hA5C3);
    sb_push(16'hA5C3);
    tick();
    in_valid = 1'b0;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_fill", 32'(fill), 32'd1);
    chk("single_first_bit", 32'(bit_out), 32'd1);
    repeat (NC) tick();
    chk("single_fill_end", 32'(fill), 32'd0);
    chk("single_valid_end", 32'(out_valid), 32'd0);
    chk("single_q_empty", 32'(q.size()), 32'd0);

    // Back-to-back fill with downstream stalled
    out_ready = 1'b0;
    bb[0] = 16'h1234; bb[1] = 16'hBEEF; bb[2] = 16'h0F0F;
    bb[3] = 16'h8001; bb[4] = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      drive(bb[i]);
      chk("bb_in_ready", 32'(in_ready), (i < DP) ? 32'd1 : 32'd0);
      if (i < DP) sb_push(bb[i]);
      tick();
    end
    in_valid = 1'b0;
    chk("bb_dropped", 32'(dropped), 32'd1);
    chk("bb_fill", 32'(fill), 32'd4);
    chk("bb_in_ready_low", 32'(in_ready), 32'd0);
    chk("bb_hold_bit", 32'(bit_out), 32'd0);
    chk("bb_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (DP * NC) tick();
    chk("bb_drained", 32'(fill), 32'd0);
    chk("bb_q_empty", 32'(q.size()), 32'd0);

    // Stall mid-word
    out_ready = 1'b1;
    drive(16'hFFFF);
    sb_push(16'hFFFF);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_bit", 32'(bit_out), 32'd1);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    chk("stall_remaining", 32'(q.size()), 32'd9);
    out_ready = 1'b1;
    repeat (9) tick();
    chk("stall_fill_end", 32'(fill), 32'd0);
    chk("stall_q_empty", 32'(q.size()), 32'd0);

    // Dropped push coinciding with the last-bit pop at full
    out_ready = 1'b0;
    for (int i = 0; i < DP; i++) begin
      w = 16'(i * 16'h1111 + 16'h0123);
      drive(w);
      sb_push(w);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (NC - 1) tick();
    drive(16'hCAFE);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("full_fill", 32'(fill), 32'd3);
    chk("full_dropped", 32'(dropped), 32'd2);
    chk("full_in_ready_back", 32'(in_ready), 32'd1);
    repeat (3 * NC) tick();
    chk("full_drained", 32'(fill), 32'd0);

    // Flush during word 2 bit 5
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 16'(16'h9C00 + i);
      drive(w);
      sb_push(w);
      tick();
    end
    in_valid = 1'b0;
    repeat (NC + 5 - 2) tick();
    chk("pre_flush_remaining", 32'(q.size()), 32'(3 * NC - NC - 5));
    flush = 1'b1;
    q.delete();
    tick();
    flush = 1'b0;
    chk("flush_fill", 32'(fill), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_dropped", 32'(dropped), 32'd2);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(16'h00FF);
    sb_push(16'h00FF);
    tick();
    in_valid = 1'b0;
    chk("prereset_valid", 32'(out_valid), 32'd1);
    #2;
    rstb = 1'b0;
    q.delete();
    #1;
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_bit_out", 32'(bit_out), 32'd0);
    chk("arst_dropped", 32'(dropped), 32'd0);
    @(posedge clk);
    #3;
    rstb = 1'b1;
    tick();

    // Long random stream at 1/16 rate
    gap = NC;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (gap >= NC && model_fill() < DP) begin
        w = 16'($urandom);
        drive(w);
        chk("rand_in_ready", 32'(in_ready), 32'd1);
        sb_push(w);
        sent++;
        gap = 1;
      end else begin
        in_valid = 1'b0;
        gap++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_all_sent", 32'(sent), 32'd1000);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++)
      tick();
    tick();
    chk("rand_q_empty", 32'(q.size()), 32'd0);
    chk("rand_fill", 32'(fill), 32'd0);
    chk("rand_dropped", 32'(dropped), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
